ps2_keyboard_rx: RTL and testbench
==================================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, is the number of consecutive clk50 cycles ps2_clk must hold a new level before that level is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, is the maximum number of clk50 cycles allowed between accepted ps2_clk falling edges inside a frame (1 ms at 50 MHz).
REQ-003 Port clk50, input, 1, is the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1, is an asynchronous, active-high reset.
REQ-005 Port ps2_clk, input, 1, is the PS/2 device clock, asynchronous to clk50.
REQ-006 Port ps2_data, input, 1, is the PS/2 device data, asynchronous to clk50.
REQ-007 Port scan_code, output, 8, is the last correctly received raw byte.
REQ-008 Port scan_valid, output, 1, is a one-cycle pulse that marks a new scan_code.
REQ-009 Port key_out, output, 16, is the Hack keyboard-map word: the code of the held key, or 0 when no key is held.
REQ-010 Port key_valid, output, 1, is a one-cycle pulse asserted whenever key_out is written.
REQ-011 Port frame_err, output, 1, is a one-cycle pulse flagging a parity, stop-bit or timeout error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The synchronized ps2_clk SHALL be deglitched by FILTER_LEN, and a falling edge SHALL be declared only on an accepted transition from 1 to 0.
REQ-014 Data SHALL be sampled on the clk50 cycle in which a filtered falling edge is declared.
REQ-015 The frame FSM SHALL use the following states and transitions:
- IDLE to DATA when the sample is 0 (start bit); a sample of 1 stays in IDLE.
- DATA collects 8 bits, LSB first, using a 3-bit counter, then moves to PARITY.
- PARITY moves to STOP.
- STOP returns to IDLE.
REQ-016 A frame SHALL be accepted only if data plus the parity bit has odd parity and the stop bit is 1.
REQ-017 On frame acceptance, scan_code SHALL update and scan_valid SHALL pulse in the cycle after the stop-bit sample.
REQ-018 On a parity or stop-bit failure, the byte SHALL be discarded, frame_err SHALL pulse once, the FSM SHALL return to IDLE, and the E0/F0 prefix flags SHALL clear.
REQ-019 If no falling edge arrives within TIMEOUT_CYCLES while in DATA, PARITY or STOP, the FSM SHALL abort to IDLE, frame_err SHALL pulse once, and prefix flags SHALL clear.
REQ-020 The timeout counter SHALL saturate and SHALL not count in IDLE.
REQ-021 Byte decode SHALL occur in the cycle after scan_valid.
- E0 sets the ext flag.
- F0 sets the brk flag.
- Any other byte is a key byte; ext and brk SHALL clear after each key byte.
REQ-022 Key bytes SHALL translate to Hack codes as follows:
- Letters A..Z map to 65..90, from set-2 bytes 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
- Digits 0..9 map to 48..57, from bytes 45,16,1E,26,25,2E,36,3D,3E,46.
- Space 29 maps to 32, Enter 5A to 128, Backspace 66 to 129, Esc 76 to 140.
- With ext set: 6B maps to 130 (left), 75 to 131 (up), 74 to 132 (right), 72 to 133 (down).
- Any other byte, or a non-arrow byte with ext set, is unmapped.
REQ-023 On a make (brk=0) of a mapped key, key_out SHALL take the new code and key_valid SHALL pulse, including on typematic repeats of the same key.
REQ-024 A later make SHALL replace the current key_out.
REQ-025 On a break (brk=1) whose translated code equals key_out, key_out SHALL become 0 and key_valid SHALL pulse.
REQ-026 A break for any other key SHALL leave key_out unchanged with no pulse.
REQ-027 Unmapped make or break bytes SHALL leave key_out unchanged with no key_valid pulse; scan_valid still pulses for them.
REQ-028 Back-to-back frames SHALL be received with no lost bytes, since decode completes before the next possible falling edge.

Reset
REQ-029 While reset is high, all of the following SHALL hold: FSM in IDLE; bit, filter and timeout counters at 0; synchronizers at 1; scan_code=0x00; key_out=0x0000; scan_valid, key_valid and frame_err at 0; ext and brk clear.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame, and the first frame after deassertion SHALL be received normally.

Verification
REQ-031 Send frame 0x1C with good parity -> scan_code=0x1C, one scan_valid pulse, key_out=65, one key_valid pulse.
REQ-032 Send F0 then 1C while key_out=65 -> key_out=0, key_valid pulses only on the 1C byte; sending F0 then 32 instead -> key_out stays 65.
REQ-033 Send E0 75 -> key_out=131; then E0 F0 75 -> key_out=0.
REQ-034 Send 0x29 with parity bit inverted -> frame_err pulses once, scan_valid does not pulse, key_out unchanged; then a following good 0x29 -> key_out=32.
REQ-035 Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES+10 cycles -> frame_err pulses once, FSM in IDLE; then a good 0x45 -> key_out=48.
REQ-036 Put 3-cycle low glitches on ps2_clk with FILTER_LEN=8 -> no bit accepted; assert reset mid-frame -> all outputs return to their reset values.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - PS/2 line inputs and decoded keyboard outputs
interface ps2_keyboard_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic [15:0] key_out;
  logic        key_valid;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, scan_valid, key_out, key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, scan_valid, key_out, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 set-2 frame receiver with Hack keyboard-map decode
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk50,
  input  logic             reset,
  ps2_keyboard_rx_if.slave bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_done, fall;
  logic [TW-1:0] to_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          do_shift, do_par, accept, bad;
  logic [7:0]    scan_code_r;
  logic          scan_valid_r, frame_err_r, key_valid_r;
  logic [15:0]   key_out_r;
  logic          ext, brk;
  logic [7:0]    key_code;

  function automatic logic [7:0] xlate(input logic [7:0] b, input logic e);
    logic [7:0] c;
    c = 8'd0;
    if (e) begin
      case (b)
        8'h6B: c = 8'd130;
        8'h75: c = 8'd131;
        8'h74: c = 8'd132;
        8'h72: c = 8'd133;
        default: c = 8'd0;
      endcase
    end else begin
      case (b)
        8'h1C: c = 8'd65;  8'h32: c = 8'd66;  8'h21: c = 8'd67;  8'h23: c = 8'd68;
        8'h24: c = 8'd69;  8'h2B: c = 8'd70;  8'h34: c = 8'd71;  8'h33: c = 8'd72;
        8'h43: c = 8'd73;  8'h3B: c = 8'd74;  8'h42: c = 8'd75;  8'h4B: c = 8'd76;
        8'h3A: c = 8'd77;  8'h31: c = 8'd78;  8'h44: c = 8'd79;  8'h4D: c = 8'd80;
        8'h15: c = 8'd81;  8'h2D: c = 8'd82;  8'h1B: c = 8'd83;  8'h2C: c = 8'd84;
        8'h3C: c = 8'd85;  8'h2A: c = 8'd86;  8'h1D: c = 8'd87;  8'h22: c = 8'd88;
        8'h35: c = 8'd89;  8'h1A: c = 8'd90;
        8'h45: c = 8'd48;  8'h16: c = 8'd49;  8'h1E: c = 8'd50;  8'h26: c = 8'd51;
        8'h25: c = 8'd52;  8'h2E: c = 8'd53;  8'h36: c = 8'd54;  8'h3D: c = 8'd55;
        8'h3E: c = 8'd56;  8'h46: c = 8'd57;
        8'h29: c = 8'd32;  8'h5A: c = 8'd128; 8'h66: c = 8'd129; 8'h76: c = 8'd140;
        default: c = 8'd0;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= bus.ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= bus.ps2_data;
      data_s2 <= data_s1;
    end
  end

  // A new ps2_clk level is taken only after FILTER_LEN unbroken cycles.
  assign filt_done = (clk_s2 != clk_filt) && (filt_cnt == FILT_LAST);
  assign fall      = filt_done && !clk_s2;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 != clk_filt) begin
      if (filt_done) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_shift = 1'b0;
    do_par   = 1'b0;
    accept   = 1'b0;
    bad      = 1'b0;
    case (state)
      IDLE:   if (fall && !data_s2) state_n = DATA;
      DATA:   if (fall) begin
                do_shift = 1'b1;
                if (bit_cnt == 3'd7) state_n = PARITY;
              end
      PARITY: if (fall) begin
                do_par  = 1'b1;
                state_n = STOP;
              end
      STOP:   if (fall) begin
                state_n = IDLE;
                if (data_s2 && (^{shreg, par_bit})) accept = 1'b1;
                else                                bad    = 1'b1;
              end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TO_MAX) begin
      state_n = IDLE;
      bad     = 1'b1;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      to_cnt       <= '0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      par_bit      <= 1'b0;
      scan_code_r  <= 8'h00;
      scan_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      if (state == IDLE || fall)  to_cnt <= '0;
      else if (to_cnt != TO_MAX)  to_cnt <= to_cnt + 1'b1;
      if (state_n == IDLE)        bit_cnt <= 3'd0;
      else if (do_shift)          bit_cnt <= bit_cnt + 3'd1;
      if (do_shift) shreg   <= {data_s2, shreg[7:1]};
      if (do_par)   par_bit <= data_s2;
      if (accept)   scan_code_r <= shreg;
      scan_valid_r <= accept;
      frame_err_r  <= bad;
    end
  end

  assign key_code = xlate(scan_code_r, ext);

  // Prefix flags persist across E0/F0 and are consumed by the next key byte.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      key_out_r   <= 16'h0000;
      key_valid_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (scan_valid_r) begin
        if (scan_code_r == 8'hE0) begin
          ext <= 1'b1;
        end else if (scan_code_r == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (key_code != 8'd0) begin
            if (!brk) begin
              key_out_r   <= {8'h00, key_code};
              key_valid_r <= 1'b1;
            end else if ({8'h00, key_code} == key_out_r) begin
              key_out_r   <= 16'h0000;
              key_valid_r <= 1'b1;
            end
          end
        end
      end
      if (bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign bus.scan_code  = scan_code_r;
  assign bus.scan_valid = scan_valid_r;
  assign bus.key_out    = key_out_r;
  assign bus.key_valid  = key_valid_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - scoreboard bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
  localparam int HALF = 20;
  localparam int TO   = 1000;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk50 = ~clk50;

  logic [7:0]  q_scan[$];
  logic [15:0] q_key[$];
  int          q_err = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_sv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk50) begin
    if (!reset) begin
      if (bus.scan_valid) begin
        if (q_scan.size() == 0) begin
          checks++; failures++;
          $display("FAIL scan_unexpected actual=%0h expected=none", bus.scan_code);
        end else begin
          chk("scan_code", bus.scan_code, q_scan.pop_front());
        end
      end
      if (bus.key_valid) begin
        chk("key_after_scan", prev_sv, 1);
        if (q_key.size() == 0) begin
          checks++; failures++;
          $display("FAIL key_unexpected actual=%0d expected=none", bus.key_out);
        end else begin
          chk("key_out", bus.key_out, q_key.pop_front());
        end
      end
      if (bus.frame_err) begin
        checks++;
        if (q_err == 0) begin
          failures++;
          $display("FAIL frame_err_unexpected actual=1 expected=0");
        end else begin
          q_err--;
        end
      end
      prev_sv = bus.scan_valid;
    end else begin
      prev_sv = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    bus.ps2_data = v;
    if (glitch) begin
      step(5);
      bus.ps2_clk = 1'b0;
      step(3);
      bus.ps2_clk = 1'b1;
      step(HALF - 8);
    end else begin
      step(HALF);
    end
    bus.ps2_clk = 1'b0;
    step(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0,
                            input logic bad_stop = 1'b0, input logic glitch = 1'b0);
    if (bad_par || bad_stop) q_err++;
    else                     q_scan.push_back(b);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ bad_par, glitch);
    send_bit(~bad_stop, glitch);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_scan_code"},  bus.scan_code, 0);
    chk({tag, "_key_out"},    bus.key_out, 0);
    chk({tag, "_scan_valid"}, bus.scan_valid, 0);
    chk({tag, "_key_valid"},  bus.key_valid, 0);
    chk({tag, "_frame_err"},  bus.frame_err, 0);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    step(5);
    check_reset_outputs("reset");
    reset = 1'b0;
    step(10);

    q_key.push_back(16'd65);
    send_frame(8'h1C);
    step(5);
    chk("make_A", bus.key_out, 65);

    q_key.push_back(16'd0);
    send_frame(8'hF0);
    send_frame(8'h1C);
    step(5);
    chk("break_A", bus.key_out, 0);

    q_key.push_back(16'd65);
    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h32);
    step(5);
    chk("break_other", bus.key_out, 65);
    chk("break_other_scan", bus.scan_code, 8'h32);

    q_key.push_back(16'd131);
    send_frame(8'hE0);
    send_frame(8'h75);
    step(5);
    chk("make_up", bus.key_out, 131);
    q_key.push_back(16'd0);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    step(5);
    chk("break_up", bus.key_out, 0);

    send_frame(8'h29, 1'b1);
    step(5);
    chk("bad_par_key", bus.key_out, 0);
    chk("bad_par_scan", bus.scan_code, 8'h75);
    q_key.push_back(16'd32);
    send_frame(8'h29);
    q_key.push_back(16'd32);
    send_frame(8'h29);
    step(5);
    chk("space_repeat", bus.key_out, 32);

    send_frame(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1);
    q_key.push_back(16'd32);
    send_frame(8'h29);
    send_frame(8'h0E);
    send_frame(8'h75);
    step(5);
    chk("err_clears_brk", bus.key_out, 32);

    q_err++;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    step(TO + 10);
    chk("timeout_err_seen", q_err, 0);
    q_key.push_back(16'd48);
    send_frame(8'h45);
    step(5);
    chk("after_timeout", bus.key_out, 48);

    bus.ps2_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ps2_clk = 1'b0;
      step(3);
      bus.ps2_clk = 1'b1;
      step(10);
    end
    q_key.push_back(16'd65);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    step(5);
    chk("glitch_frame", bus.key_out, 65);

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    step(3);
    check_reset_outputs("midreset");
    reset = 1'b0;
    step(HALF);
    q_key.push_back(16'd49);
    send_frame(8'h16);
    step(5);
    chk("after_reset", bus.key_out, 49);

    step(50);
    chk("scan_queue_empty", q_scan.size(), 0);
    chk("key_queue_empty", q_key.size(), 0);
    chk("err_queue_empty", q_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
